alu_serial_rx: RTL and testbench
================================

# alu_serial_rx

Serial frame receiver for the ALU command port: deserializes the `sin` bit stream into 11-bit packets and assembles 8 data packets plus one control packet into an operation. It checks framing, packet count, CRC4 and opcode, then emits either a validated operand/opcode bundle or one error code. It sits between the `sin` pin and the ALU core, as the DUT-side counterpart of the bench's serial command driver.

## Interface
- No parameters. Widths and constants are fixed by the protocol.
- clk  in  1  system clock; `sin` is sampled on every rising edge, one bit per clock.
- rst_n  in  1  synchronous, active-low reset.
- sin  in  1  serial command line; idles high.
- out_valid  out  1  one-cycle pulse: `out_a`, `out_b` and `out_op` hold a validated command.
- out_a  out  32  operand A.
- out_b  out  32  operand B.
- out_op  out  3  opcode: and 000, or 001, add 100, sub 101.
- err_valid  out  1  one-cycle pulse: `err_code` holds an error code.
- err_code  out  8  DATA_ERROR 8'hC9, CRC_ERROR 8'hA5, OP_ERROR 8'h93.

## Operation
- **Packet format**, 11 bits, MSB first: start 0, type (0 data / 1 control), 8 payload bits, stop 1.
- **Command sequence**:
  - Data packets carry B[31:24], B[23:16], B[15:8], B[7:0], then A[31:24] down to A[7:0].
  - The control packet payload is {1'b0, OP[2:0], CRC[3:0]}.
- **CRC4**:
  - Polynomial x^4+x+1, initial value 4'h0, no final XOR.
  - Computed over the 68-bit stream {B, A, 1'b1, OP}, MSB first.
  - It may be computed serially or all at once in the check cycle; the result latency below is fixed either way.
- **Packet FSM**: IDLE -> SHIFT (10 bits) -> IDLE.
  - In IDLE, `sin`=0 starts a packet; `sin`=1 stays in IDLE.
  - SHIFT captures the type, payload and stop bits.
- **Command tracking**:
  - A data-packet counter (0..8) saturates at 8.
  - An overflow flag is set if a data packet arrives while the count is already 8.
- **Evaluation at the end of each packet**, in priority order:
  - Stop bit = 0 (framing error): DATA_ERROR. Clear the counter and flag and discard the partial command.
  - Data packet: store the byte in the slot given by the counter, then increment the counter. No output.
  - Control packet with counter ≠ 8 or overflow flag set: DATA_ERROR.
  - Otherwise, CRC mismatch: CRC_ERROR.
  - Otherwise, OP not in {000, 001, 100, 101}: OP_ERROR.
  - Otherwise: `out_valid` pulses with A, B and OP.
  - After any control packet, or any error, clear the counter and flag.
- **Mutual exclusion**: exactly one of `out_valid` or `err_valid` pulses per control packet. They are never high together.
- **Output hold**:
  - `out_a`, `out_b` and `out_op` hold their value until the next valid command.
  - `err_code` holds until the next error.

## Timing
- **Reset values**: `out_valid`=0, `err_valid`=0, `out_a`=0, `out_b`=0, `out_op`=3'b000, `err_code`=8'h00. FSM in IDLE, counter 0, overflow flag clear, CRC state cleared.
- **Packet sampling**: the start bit is sampled at edge T0. Type is sampled at T1, payload at T2..T9, stop at T10.
- **Result latency**: `out_valid` or `err_valid` is asserted by edge T11 and is high for exactly one clock.
- **Back-to-back packets**: the next start bit may be sampled at T11. No idle gap is required and no packet is lost.
- **Idle between packets**: any number of idle (1) cycles between packets, or between commands, is legal and does not reset the command state.
- **Reset mid-operation**: `rst_n`=0 on any edge aborts the packet and the command. No pulse is produced, and outputs return to their reset values on that edge.
- **Stop-bit error**: a 0 on the stop bit does not re-arm from that 0. The FSM returns to IDLE and waits for the next 0 sampled in IDLE.

## Test plan
- **Valid add**: A=32'h0000_0001, B=32'h0000_0002, op=100, correct CRC4 from the bench model -> `out_valid` pulses 1 clock at T11 of the control packet, `out_a`=1, `out_b`=2, `out_op`=100, `err_valid` stays 0.
- **Bad CRC**: same command with CRC XOR 4'h1 -> `err_valid` pulses with `err_code`=8'hA5, no `out_valid`.
- **Bad opcode**: op=010 with a correct CRC -> `err_code`=8'h93.
- **Wrong packet count**:
  - 7 data packets, then a control packet -> `err_code`=8'hC9.
  - 9 data packets, then a control packet -> 8'hC9.
  - A following correct 8+1 command -> `out_valid`.
- **Framing error and back-to-back**:
  - Stop bit = 0 in the 3rd data packet -> immediate 8'hC9.
  - Two valid commands sent with zero idle cycles between them -> two `out_valid` pulses, with the correct A/B/op each time.
- **Reset and idle gaps**:
  - `rst_n`=0 for 1 clock after 5 data packets -> outputs reset, no pulse. A fresh full command afterwards -> `out_valid`.
  - Random idle gaps (0..20 cycles) between packets -> results unchanged.

Source files
------------

// File: rtl/alu_serial_rx.sv
// alu_serial_rx: serial command receiver for the ALU.
// Deserializes 11-bit packets from sin (start, type, 8 payload, stop), collects
// 8 data packets (B then A, MSB byte first) plus a control packet
// {0, OP, CRC4}, validates framing, count, CRC4 and opcode, then emits one
// registered result pulse one clock after the stop bit is sampled.
// Ports:
//   clk        system clock, sin sampled every rising edge
//   rst_n      synchronous active-low reset
//   sin        serial input, idles high
//   out_valid  1-cycle pulse, out_a/out_b/out_op hold a validated command
//   out_a      operand A (held until next valid command)
//   out_b      operand B (held until next valid command)
//   out_op     opcode (held until next valid command)
//   err_valid  1-cycle pulse, err_code holds an error code
//   err_code   error code (held until next error)
module alu_serial_rx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        out_valid,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [2:0]  out_op,
  output logic        err_valid,
  output logic [7:0]  err_code
);

  localparam int unsigned PKT_BITS  = 10;  // bits after the start bit
  localparam int unsigned BIT_W     = 4;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned DATA_PKTS = 8;
  localparam int unsigned DATA_W    = 64;

  localparam logic [7:0] DATA_ERROR = 8'hC9;
  localparam logic [7:0] CRC_ERROR  = 8'hA5;
  localparam logic [7:0] OP_ERROR   = 8'h93;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state_q, state_d;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic [PKT_BITS-1:0]   shreg_q;
  logic                  pkt_done_q;
  logic [CNT_W-1:0]      dcnt_q;
  logic                  ovf_q;
  logic [DATA_W-1:0]     data_q;

  logic                  shift_en_c;
  logic                  last_bit_c;

  // CRC4, poly x^4+x+1, init 0, processed MSB first
  function automatic logic [3:0] crc4(input logic [67:0] msg);
    logic [3:0] crc;
    logic       fb;
    crc = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb  = crc[3] ^ msg[i];
      crc = {crc[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return crc;
  endfunction

  // Packet FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Packet FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!sin) state_d = SHIFT;
      SHIFT:   if (last_bit_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Packet FSM outputs
  always_comb begin
    shift_en_c = 1'b0;
    last_bit_c = 1'b0;
    if (state_q == SHIFT) begin
      shift_en_c = 1'b1;
      last_bit_c = (bit_cnt_q == BIT_W'(PKT_BITS - 1));
    end
  end

  // Bit shifter; pkt_done_q flags a complete packet for evaluation next edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      pkt_done_q <= last_bit_c;
      if (shift_en_c) begin
        shreg_q   <= {shreg_q[PKT_BITS-2:0], sin};
        bit_cnt_q <= last_bit_c ? '0 : bit_cnt_q + BIT_W'(1);
      end
    end
  end

  // Completed packet fields: shreg_q = {type, payload[7:0], stop}
  logic       stop_c;
  logic       ctrl_c;
  logic [7:0] payload_c;
  logic [2:0] op_c;
  logic [3:0] crc_rx_c;
  logic [3:0] crc_calc_c;
  logic       op_ok_c;

  always_comb begin
    stop_c     = shreg_q[0];
    ctrl_c     = shreg_q[PKT_BITS-1];
    payload_c  = shreg_q[8:1];
    op_c       = payload_c[6:4];
    crc_rx_c   = payload_c[3:0];
    crc_calc_c = crc4({data_q, 1'b1, op_c});
    case (op_c)
      3'b000, 3'b001, 3'b100, 3'b101: op_ok_c = 1'b1;
      default:                        op_ok_c = 1'b0;
    endcase
  end

  // Command assembly and result evaluation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dcnt_q    <= '0;
      ovf_q     <= 1'b0;
      data_q    <= '0;
      out_valid <= 1'b0;
      err_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_op    <= '0;
      err_code  <= '0;
    end else begin
      out_valid <= 1'b0;
      err_valid <= 1'b0;
      if (pkt_done_q) begin
        if (!stop_c) begin
          err_valid <= 1'b1;
          err_code  <= DATA_ERROR;
          dcnt_q    <= '0;
          ovf_q     <= 1'b0;
        end else if (!ctrl_c) begin
          // data bytes shift in, so after 8 packets data_q = {B, A}
          if (dcnt_q == CNT_W'(DATA_PKTS)) begin
            ovf_q <= 1'b1;
          end else begin
            data_q <= {data_q[DATA_W-9:0], payload_c};
            dcnt_q <= dcnt_q + CNT_W'(1);
          end
        end else begin
          dcnt_q <= '0;
          ovf_q  <= 1'b0;
          if (dcnt_q != CNT_W'(DATA_PKTS) || ovf_q) begin
            err_valid <= 1'b1;
            err_code  <= DATA_ERROR;
          end else if (crc_calc_c != crc_rx_c) begin
            err_valid <= 1'b1;
            err_code  <= CRC_ERROR;
          end else if (!op_ok_c) begin
            err_valid <= 1'b1;
            err_code  <= OP_ERROR;
          end else begin
            out_valid <= 1'b1;
            out_b     <= data_q[63:32];
            out_a     <= data_q[31:0];
            out_op    <= op_c;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_rx.sv
// Scoreboard bench for alu_serial_rx: the driver pushes the expected result
// (with the cycle it must appear on) for every control packet or framing
// error; a monitor pops and compares whenever a result pulse is seen.
module tb_alu_serial_rx;

  logic        clk;
  logic        rst_n;
  logic        sin;
  logic        out_valid;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_op;
  logic        err_valid;
  logic [7:0]  err_code;

  alu_serial_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .out_valid (out_valid),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_op    (out_op),
    .err_valid (err_valid),
    .err_code  (err_code)
  );

  typedef struct {
    bit          is_err;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [7:0]  code;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;
  logic [2:0]  last_op = '0;
  logic [7:0]  last_code = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference CRC by polynomial long division of msg*x^4 by 10011
  function automatic logic [3:0] crc_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
    logic [71:0] m;
    m = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    return m[3:0];
  endfunction

  function automatic bit op_legal(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b101);
  endfunction

  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_pkt(input logic typ, input logic [7:0] d, input logic stop,
                          output int sc);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop);
    sc = cyc;
  endtask

  task automatic push_err(input logic [7:0] code, input int sc);
    exp_t e;
    e.is_err = 1'b1; e.a = '0; e.b = '0; e.op = '0; e.code = code; e.cyc = sc + 1;
    q.push_back(e);
  endtask

  task automatic send_data(input logic [31:0] a, input logic [31:0] b, input int n,
                           input int gap);
    logic [63:0] v;
    int sc;
    v = {b, a};
    for (int k = 0; k < n; k++) begin
      send_pkt(1'b0, v[63 - 8*(k % 8) -: 8], 1'b1, sc);
      idle(int'($urandom_range(gap, 0)));
    end
  endtask

  task automatic send_ctrl(input logic [2:0] op, input logic [3:0] crc, output int sc);
    send_pkt(1'b1, {1'b0, op, crc}, 1'b1, sc);
  endtask

  // Full 8+1 command; expectation derived from the bench CRC model
  task automatic send_cmd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic [3:0] crc, input int gap);
    exp_t e;
    int sc;
    send_data(a, b, 8, gap);
    send_ctrl(op, crc, sc);
    e.a = a; e.b = b; e.op = op; e.cyc = sc + 1;
    if (crc != crc_model(a, b, op)) begin e.is_err = 1'b1; e.code = 8'hA5; end
    else if (!op_legal(op))         begin e.is_err = 1'b1; e.code = 8'h93; end
    else                            begin e.is_err = 1'b0; e.code = 8'h00; end
    q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_err_valid"}, 64'(err_valid), 64'd0);
    chk({tag, "_out_a"},     64'(out_a),     64'd0);
    chk({tag, "_out_b"},     64'(out_b),     64'd0);
    chk({tag, "_out_op"},    64'(out_op),    64'd0);
    chk({tag, "_err_code"},  64'(err_code),  64'd0);
    last_a = '0; last_b = '0; last_op = '0; last_code = '0;
  endtask

  // Monitor: compares every result pulse against the scoreboard head
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (out_valid || err_valid) begin
      chk("exclusive", 64'(out_valid & err_valid), 64'd0);
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_pulse: got out_valid=%0b err_valid=%0b expected none at cycle %0d",
                 out_valid, err_valid, cyc);
      end else begin
        e = q.pop_front();
        chk("result_cycle", 64'(cyc), 64'(e.cyc));
        if (e.is_err) begin
          chk("err_valid", 64'(err_valid), 64'd1);
          chk("err_code", 64'(err_code), 64'(e.code));
          chk("hold_out_a", 64'(out_a), 64'(last_a));
          chk("hold_out_op", 64'(out_op), 64'(last_op));
          last_code = e.code;
        end else begin
          chk("out_valid", 64'(out_valid), 64'd1);
          chk("out_a", 64'(out_a), 64'(e.a));
          chk("out_b", 64'(out_b), 64'(e.b));
          chk("out_op", 64'(out_op), 64'(e.op));
          chk("hold_err_code", 64'(err_code), 64'(last_code));
          last_a = e.a; last_b = e.b; last_op = e.op;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no finish expected finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    int sc;
    sin   = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(3);

    // Valid add, CRC 4'hC computed by hand
    send_cmd(32'h0000_0001, 32'h0000_0002, 3'b100, 4'hC, 0);
    idle(2);
    // Bad CRC
    send_cmd(32'h0000_0001, 32'h0000_0002, 3'b100, 4'hC ^ 4'h1, 0);
    idle(2);
    // Bad opcode with correct CRC
    send_cmd(32'h1234_5678, 32'h9ABC_DEF0, 3'b010,
             crc_model(32'h1234_5678, 32'h9ABC_DEF0, 3'b010), 0);
    idle(2);

    // 7 data packets then control
    send_data(32'hAAAA_5555, 32'h0F0F_F0F0, 7, 0);
    send_ctrl(3'b000, 4'h0, sc);
    push_err(8'hC9, sc);
    idle(2);
    // 9 data packets then control
    send_data(32'hAAAA_5555, 32'h0F0F_F0F0, 9, 0);
    send_ctrl(3'b000, crc_model(32'hAAAA_5555, 32'h0F0F_F0F0, 3'b000), sc);
    push_err(8'hC9, sc);
    idle(2);
    // Correct command afterwards
    send_cmd(32'hDEAD_BEEF, 32'hCAFE_F00D, 3'b001,
             crc_model(32'hDEAD_BEEF, 32'hCAFE_F00D, 3'b001), 0);
    idle(2);

    // Framing error on 3rd data packet
    send_data(32'h1111_2222, 32'h3333_4444, 2, 0);
    send_pkt(1'b0, 8'h5A, 1'b0, sc);
    push_err(8'hC9, sc);
    idle(2);
    send_cmd(32'h0000_00FF, 32'hFF00_0000, 3'b101,
             crc_model(32'h0000_00FF, 32'hFF00_0000, 3'b101), 0);

    // Two valid commands back-to-back with no idle
    send_cmd(32'h7FFF_FFFF, 32'h8000_0001, 3'b100,
             crc_model(32'h7FFF_FFFF, 32'h8000_0001, 3'b100), 0);
    send_cmd(32'h0123_4567, 32'h89AB_CDEF, 3'b000,
             crc_model(32'h0123_4567, 32'h89AB_CDEF, 3'b000), 0);
    idle(3);

    // Reset after 5 data packets aborts the command
    send_data(32'h5555_AAAA, 32'h6666_9999, 5, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    idle(2);
    send_cmd(32'hFEED_FACE, 32'h0BAD_C0DE, 3'b101,
             crc_model(32'hFEED_FACE, 32'h0BAD_C0DE, 3'b101), 0);
    idle(2);

    // Random idle gaps 0..20 between packets
    send_cmd(32'hA5A5_A5A5, 32'h5A5A_5A5A, 3'b001,
             crc_model(32'hA5A5_A5A5, 32'h5A5A_5A5A, 3'b001), 20);
    idle(int'($urandom_range(20, 0)));
    send_cmd(32'h0000_0001, 32'h0000_0002, 3'b100, 4'hC ^ 4'h8, 20);
    idle(int'($urandom_range(20, 0)));
    send_cmd(32'h0000_0001, 32'h0000_0002, 3'b100, 4'hC, 20);

    idle(30);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
